// File: rtl/ysyx_23060025_mem_arbiter.sv
// rtl/ysyx_23060025_mem_arbiter.sv - two-requester arbiter/sequencer for the shared memory port (option: ARB_ROUND_ROBIN_EN)
module ysyx_23060025_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [7:0]              m0_len,
    output logic                    m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rsp_data,
    output logic                    m0_rsp_last,
    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_wen,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rsp_data,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_wen,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic [7:0]              s_len,
    input  logic                    s_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   s_rsp_data,
    input  logic                    s_rsp_last,
    output logic                    arb_busy
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t state;
    logic   grant;
    logic   winner;
    logic   any_req;
    logic   both_req;
    logic   is_idle;
    logic   rsp_fwd;

`ifndef ARB_ROUND_ROBIN_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
`endif

    assign any_req  = m0_req_valid | m1_req_valid;
    assign both_req = m0_req_valid & m1_req_valid;
    assign is_idle  = (state == IDLE);
    assign arb_busy = ~is_idle;

    // Pick the winner: 1 selects the LSU, 0 the icache refill path
    always_comb begin
        winner = 1'b0;
        if (both_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~grant;
`else
            winner = (starve_cnt == SW'(STARVE_LIMIT)) ? 1'b0 : 1'b1;
`endif
        end else if (m1_req_valid) begin
            winner = 1'b1;
        end
    end

    assign m0_req_ready = is_idle & m0_req_valid & ~winner;
    assign m1_req_ready = is_idle & m1_req_valid & winner;

    // Sequencer: latch the winner's request, present it downstream, then wait for the last beat
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            s_req_valid <= 1'b0;
            s_addr      <= '0;
            s_wen       <= 1'b0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            s_len       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ADDR;
                        grant       <= winner;
                        s_req_valid <= 1'b1;
                        if (winner) begin
                            s_addr  <= m1_addr;
                            s_wen   <= m1_wen;
                            s_wdata <= m1_wdata;
                            s_wstrb <= m1_wstrb;
                            s_len   <= 8'd0;
                        end else begin
                            s_addr  <= m0_addr;
                            s_wen   <= 1'b0;
                            s_wdata <= '0;
                            s_wstrb <= '0;
                            s_len   <= m0_len;
                        end
                    end
                end
                ADDR: begin
                    if (s_req_ready) begin
                        state       <= RESP;
                        s_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (s_rsp_valid && s_rsp_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Count consecutive contested grants lost by the icache; cleared whenever it wins
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (is_idle && any_req) begin
            if (!winner) begin
                starve_cnt <= '0;
            end else if (both_req && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end
`endif

    // Route response beats to the owner only; beats outside RESP are dropped
    always_comb begin
        rsp_fwd      = (state == RESP) & s_rsp_valid;
        m0_rsp_valid = rsp_fwd & ~grant;
        m1_rsp_valid = rsp_fwd & grant;
        m0_rsp_last  = m0_rsp_valid & s_rsp_last;
        m0_rsp_data  = m0_rsp_valid ? s_rsp_data : '0;
        m1_rsp_data  = m1_rsp_valid ? s_rsp_data : '0;
    end

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// tb/tb_ysyx_23060025_mem_arbiter.sv - scoreboard bench for ysyx_23060025_mem_arbiter
module tb_ysyx_23060025_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req_valid, m0_req_ready;
    logic [31:0] m0_addr;
    logic [7:0]  m0_len;
    logic        m0_rsp_valid, m0_rsp_last;
    logic [31:0] m0_rsp_data;
    logic        m1_req_valid, m1_req_ready;
    logic [31:0] m1_addr;
    logic        m1_wen;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_data;
    logic        s_req_valid, s_req_ready;
    logic [31:0] s_addr;
    logic        s_wen;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [7:0]  s_len;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_data;
    logic        s_rsp_last;
    logic        arb_busy;

    ysyx_23060025_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_addr(m0_addr), .m0_len(m0_len),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_last(m0_rsp_last),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_len(s_len),
        .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data), .s_rsp_last(s_rsp_last),
        .arb_busy(arb_busy)
    );

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] cur_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic who, input logic [31:0] data, input logic last);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic issue(input logic who, input logic [31:0] addr, input logic [7:0] len,
                         input logic wen, input logic [31:0] wd, input logic [3:0] ws,
                         output int waited);
        if (who == 1'b0) begin
            m0_req_valid = 1'b1; m0_addr = addr; m0_len = len;
        end else begin
            m1_req_valid = 1'b1; m1_addr = addr; m1_wen = wen; m1_wdata = wd; m1_wstrb = ws;
        end
        cur_addr = addr;
        #1;
        waited = 0;
        while (!(who ? m1_req_ready : m0_req_ready) && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_ready", {63'd0, (who ? m1_req_ready : m0_req_ready)}, 64'd1);
        tick();
        if (who == 1'b0) m0_req_valid = 1'b0;
        else             m1_req_valid = 1'b0;
        #1;
        chk("s_req_valid", {63'd0, s_req_valid}, 64'd1);
        chk("s_addr", {32'd0, s_addr}, {32'd0, addr});
        chk("s_len", {56'd0, s_len}, {56'd0, (who ? 8'd0 : len)});
        chk("s_wen", {63'd0, s_wen}, {63'd0, (who ? wen : 1'b0)});
        if (who && wen) begin
            chk("s_wdata", {32'd0, s_wdata}, {32'd0, wd});
            chk("s_wstrb", {60'd0, s_wstrb}, {60'd0, ws});
        end
    endtask

    // Downstream model: optional ready delay, then beats of seed*(i+1); reset_at asserts reset during that beat
    task automatic serve(input int nbeats, input int delay, input logic [31:0] seed, input int reset_at);
        int n;
        n = 0;
        while (!s_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("s_req_wait", {63'd0, s_req_valid}, 64'd1);
        for (int d = 0; d < delay; d++) begin
            chk("s_req_hold", {63'd0, s_req_valid}, 64'd1);
            chk("s_addr_hold", {32'd0, s_addr}, {32'd0, cur_addr});
            tick();
        end
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            exp_t e;
            s_rsp_valid = 1'b1;
            s_rsp_data  = 32'(seed * 32'(i + 1));
            s_rsp_last  = (i == nbeats - 1);
            if (i == reset_at) reset = 1'b1;
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.who == 1'b0) begin
                    chk("m0_rsp_valid", {63'd0, m0_rsp_valid}, 64'd1);
                    chk("m0_rsp_data", {32'd0, m0_rsp_data}, {32'd0, e.data});
                    chk("m0_rsp_last", {63'd0, m0_rsp_last}, {63'd0, e.last});
                    chk("m1_rsp_quiet", {63'd0, m1_rsp_valid}, 64'd0);
                end else begin
                    chk("m1_rsp_valid", {63'd0, m1_rsp_valid}, 64'd1);
                    chk("m1_rsp_data", {32'd0, m1_rsp_data}, {32'd0, e.data});
                    chk("m0_rsp_quiet", {62'd0, m0_rsp_valid, m0_rsp_last}, 64'd0);
                end
            end
            tick();
            if (i == reset_at) begin
                s_rsp_valid = 1'b0;
                s_rsp_last  = 1'b0;
                #1;
                chk("rst_ctrl", {58'd0, arb_busy, s_req_valid, s_wen, m0_rsp_valid, m1_rsp_valid, m0_rsp_last}, 64'd0);
                chk("rst_addr", {32'd0, s_addr}, 64'd0);
                chk("rst_len_wstrb", {52'd0, s_len, s_wstrb}, 64'd0);
                chk("rst_wdata", {32'd0, s_wdata}, 64'd0);
                sb.delete();
                return;
            end
        end
        s_rsp_valid = 1'b0;
        s_rsp_last  = 1'b0;
        s_rsp_data  = 32'd0;
        #1;
        chk("back_idle", {63'd0, arb_busy}, 64'd0);
    endtask

    initial begin
        int   w;
        logic exp_g;
        reset = 1'b1;
        m0_req_valid = 0; m0_addr = 0; m0_len = 0;
        m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wstrb = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_data = 0; s_rsp_last = 0;
        tick();
        tick();
        chk("reset_ctrl", {59'd0, arb_busy, s_req_valid, m0_req_ready, m1_req_ready, s_wen}, 64'd0);
        chk("reset_addr", {32'd0, s_addr}, 64'd0);
        reset = 1'b0;
        tick();

        // m0 burst of 4 beats, downstream ready immediately
        push_exp(1'b0, 32'h11, 1'b0);
        push_exp(1'b0, 32'h22, 1'b0);
        push_exp(1'b0, 32'h33, 1'b0);
        push_exp(1'b0, 32'h44, 1'b1);
        issue(1'b0, 32'h8000_0000, 8'd3, 1'b0, 32'd0, 4'd0, w);
        chk("m0_ready_at_T", 64'(w), 64'd0);
        serve(4, 0, 32'h11, -1);

        // m1 write with downstream ready delayed three cycles
        push_exp(1'b1, 32'h0000_00A5, 1'b1);
        issue(1'b1, 32'h8000_0100, 8'd0, 1'b1, 32'hDEAD_BEEF, 4'hF, w);
        serve(1, 3, 32'h0000_00A5, -1);

        // contested arbitration, fresh from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_addr = 32'h0000_1000; m0_len = 8'd0;
        m1_addr = 32'h0000_2000; m1_wen = 1'b0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
        m0_req_valid = 1'b1;
        m1_req_valid = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 1'b1 : 1'b0;
`else
            exp_g = (i == 4) ? 1'b0 : 1'b1;
            if (i == 4) chk("starve_before", 64'(dut.starve_cnt), 64'd4);
`endif
            chk("arb_m0_ready", {63'd0, m0_req_ready}, {63'd0, ~exp_g});
            chk("arb_m1_ready", {63'd0, m1_req_ready}, {63'd0, exp_g});
            cur_addr = exp_g ? 32'h0000_2000 : 32'h0000_1000;
            tick();
`ifndef ARB_ROUND_ROBIN_EN
            if (i == 4) chk("starve_after", 64'(dut.starve_cnt), 64'd0);
`endif
            chk("arb_s_addr", {32'd0, s_addr}, {32'd0, cur_addr});
            push_exp(exp_g, 32'h100 + 32'(i), 1'b1);
            serve(1, 0, 32'h100 + 32'(i), -1);
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        tick();

        // reset during beat 2 of a 4-beat burst, then an m1 read right after
        push_exp(1'b0, 32'h55, 1'b0);
        push_exp(1'b0, 32'hAA, 1'b0);
        push_exp(1'b0, 32'hFF, 1'b0);
        push_exp(1'b0, 32'h154, 1'b1);
        issue(1'b0, 32'h8000_0200, 8'd3, 1'b0, 32'd0, 4'd0, w);
        serve(4, 0, 32'h55, 1);
        reset = 1'b0;
        push_exp(1'b1, 32'h77, 1'b1);
        issue(1'b1, 32'h8000_0300, 8'd0, 1'b0, 32'd0, 4'd0, w);
        chk("m1_after_reset", 64'(w), 64'd0);
        serve(1, 0, 32'h77, -1);

        // stray response beat while idle
        tick();
        s_rsp_valid = 1'b1;
        s_rsp_last  = 1'b1;
        s_rsp_data  = 32'h0000_0BAD;
        #1;
        chk("stray_valid", {62'd0, m0_rsp_valid, m1_rsp_valid}, 64'd0);
        chk("stray_data", {m0_rsp_data, m1_rsp_data}, 64'd0);
        tick();
        chk("stray_idle", {63'd0, arb_busy}, 64'd0);
        s_rsp_valid = 1'b0;
        s_rsp_last  = 1'b0;
        s_rsp_data  = 32'd0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
